// File: rtl/inv_spd_from_chol_n.sv
`default_nettype none
// ============================================================================
// Module   : inv_spd_from_chol_n
// Purpose  : Inverse of an NxN SPD matrix from its inverse Cholesky factor,
//            Z = S^T * S, one MAC per enabled cycle, packed lower triangles.
// Options  : define INV_SPD_SATURATE_EN to clamp out-of-range results
//            (default build wraps to the low DW bits).
// Revision : 1.0 - initial parametrised release
// ============================================================================
module inv_spd_from_chol_n #(
    parameter int N    = 2,
    parameter int DW   = 32,
    parameter int FRAC = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          clk_en,
    input  logic [(N*(N+1)/2)*DW-1:0]     S,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic [(N*(N+1)/2)*DW-1:0]     Z,
    output logic                          out_valid,
    input  logic                          out_ready
);

    localparam int ELEMS = N * (N + 1) / 2;
    localparam int ACCW  = 2 * DW + 3;
    localparam int CW    = $clog2(N);
    localparam int EW    = $clog2(ELEMS);
    localparam logic [CW-1:0] C_LAST = CW'(N - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    state_t                   state_q;
    logic                     in_ready_q;
    logic                     out_valid_q;
    logic [ELEMS*DW-1:0]      z_q;
    logic signed [ACCW-1:0]   acc_q;
    logic [CW-1:0]            i_q;
    logic [CW-1:0]            j_q;
    logic [CW-1:0]            k_q;
    logic signed [DW-1:0]     s_q [ELEMS];

    logic signed [DW-1:0]     w_a;
    logic signed [DW-1:0]     w_b;
    logic signed [2*DW-1:0]   w_prod;
    logic signed [ACCW-1:0]   acc_d;
    logic [DW-1:0]            elem_d;
    logic [EW-1:0]            w_zidx;

    // Packed lower-triangle position of element (r,c), c <= r.
    function automatic logic [EW-1:0] tri_idx(input logic [CW-1:0] r,
                                              input logic [CW-1:0] c);
        int ri;
        ri = int'(r);
        return EW'(ri * (ri + 1) / 2 + int'(c));
    endfunction

    assign w_a    = s_q[tri_idx(k_q, i_q)];
    assign w_b    = s_q[tri_idx(k_q, j_q)];
    assign w_prod = w_a * w_b;
    assign acc_d  = acc_q + {{3{w_prod[2*DW-1]}}, w_prod};
    assign w_zidx = tri_idx(i_q, j_q);

`ifdef INV_SPD_SATURATE_EN
    localparam logic signed [ACCW-1:0] C_MAX = {{(ACCW-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [ACCW-1:0] C_MIN = {{(ACCW-DW+1){1'b1}}, {(DW-1){1'b0}}};
    logic signed [ACCW-1:0] w_shifted;

    always_comb begin
        w_shifted = acc_d >>> FRAC;
        if (w_shifted > C_MAX) begin
            elem_d = C_MAX[DW-1:0];
        end else if (w_shifted < C_MIN) begin
            elem_d = C_MIN[DW-1:0];
        end else begin
            elem_d = w_shifted[DW-1:0];
        end
    end
`else
    // Arithmetic shift then narrow keeps exactly bits [FRAC +: DW].
    assign elem_d = acc_d[FRAC +: DW];
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            z_q         <= '0;
            acc_q       <= '0;
            i_q         <= '0;
            j_q         <= '0;
            k_q         <= '0;
            for (int e = 0; e < ELEMS; e++) begin
                s_q[e] <= '0;
            end
        end else if (clk_en) begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        for (int e = 0; e < ELEMS; e++) begin
                            s_q[e] <= S[e*DW +: DW];
                        end
                        acc_q      <= '0;
                        i_q        <= '0;
                        j_q        <= '0;
                        k_q        <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    if (k_q != C_LAST) begin
                        acc_q <= acc_d;
                        k_q   <= k_q + CW'(1);
                    end else begin
                        z_q[int'(w_zidx)*DW +: DW] <= elem_d;
                        acc_q <= '0;
                        // Row-major walk; the dot product for (i,j) starts at k=i.
                        if (j_q < i_q) begin
                            j_q <= j_q + CW'(1);
                            k_q <= i_q;
                        end else if (i_q != C_LAST) begin
                            i_q <= i_q + CW'(1);
                            j_q <= '0;
                            k_q <= i_q + CW'(1);
                        end else begin
                            out_valid_q <= 1'b1;
                            state_q     <= ST_HOLD;
                        end
                    end
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign Z         = z_q;

endmodule
`default_nettype wire

// File: tb/tb_inv_spd_from_chol_n.sv
`default_nettype none
// ============================================================================
// Module   : tb_inv_spd_from_chol_n
// Purpose  : Self-checking bench for N=2 and N=3 instances against a
//            dot-product reference model of Z = S^T * S.
// Revision : 1.0 - initial release
// ============================================================================
module tb_inv_spd_from_chol_n;

    logic          clk = 1'b0;
    logic          rst;
    logic          clk_en;

    logic [95:0]   s2;
    logic [95:0]   z2;
    logic          in_valid2, in_ready2, out_valid2, out_ready2;
    logic [191:0]  s3;
    logic [191:0]  z3;
    logic          in_valid3, in_ready3, out_valid3, out_ready3;

    int            n_tests = 0;
    int            n_fail  = 0;
    int            s_in  [6];
    logic [31:0]   exp_z [6];

    always #5 clk = ~clk;

    inv_spd_from_chol_n #(.N(2), .DW(32), .FRAC(16)) dut2 (
        .clk(clk), .rst(rst), .clk_en(clk_en), .S(s2),
        .in_valid(in_valid2), .in_ready(in_ready2), .Z(z2),
        .out_valid(out_valid2), .out_ready(out_ready2)
    );

    inv_spd_from_chol_n #(.N(3), .DW(32), .FRAC(16)) dut3 (
        .clk(clk), .rst(rst), .clk_en(clk_en), .S(s3),
        .in_valid(in_valid3), .in_ready(in_ready3), .Z(z3),
        .out_valid(out_valid3), .out_ready(out_ready3)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: each element is a dot product of columns i and j of S, rows k>=i.
    function automatic void model(input int n);
        longint acc;
        longint sh;
        for (int i = 0; i < n; i++) begin
            for (int j = 0; j <= i; j++) begin
                acc = 0;
                for (int k = i; k < n; k++) begin
                    acc += longint'(s_in[k*(k+1)/2 + i]) * longint'(s_in[k*(k+1)/2 + j]);
                end
                sh = acc >>> 16;
`ifdef INV_SPD_SATURATE_EN
                if (sh > 64'sd2147483647)       exp_z[i*(i+1)/2 + j] = 32'h7FFF_FFFF;
                else if (sh < -64'sd2147483648) exp_z[i*(i+1)/2 + j] = 32'h8000_0000;
                else                            exp_z[i*(i+1)/2 + j] = sh[31:0];
`else
                exp_z[i*(i+1)/2 + j] = sh[31:0];
`endif
            end
        end
    endfunction

    function automatic logic [31:0] get_z(input int n, input int e);
        return (n == 2) ? z2[e*32 +: 32] : z3[e*32 +: 32];
    endfunction

    function automatic logic get_valid(input int n);
        return (n == 2) ? out_valid2 : out_valid3;
    endfunction

    function automatic logic get_ready(input int n);
        return (n == 2) ? in_ready2 : in_ready3;
    endfunction

    task automatic set_in_valid(input int n, input logic v);
        if (n == 2) in_valid2 = v; else in_valid3 = v;
    endtask

    task automatic set_out_ready(input int n, input logic v);
        if (n == 2) out_ready2 = v; else out_ready3 = v;
    endtask

    task automatic drive_s(input int n);
        for (int e = 0; e < n*(n+1)/2; e++) begin
            if (n == 2) s2[e*32 +: 32] = s_in[e];
            else        s3[e*32 +: 32] = s_in[e];
        end
    endtask

    task automatic scramble_s(input int n);
        if (n == 2) s2 = {$urandom, $urandom, $urandom};
        else        s3 = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    endtask

    // One full transaction: accept, optional 3-cycle clk_en stall, optional backpressure.
    task automatic run_case(input string tag, input int n, input int stall_at, input int hold_cyc);
        int elems;
        int exp_lat;
        int cyc;
        elems   = n * (n + 1) / 2;
        exp_lat = 0;
        cyc     = 0;
        for (int i = 0; i < n; i++) exp_lat += (i + 1) * (n - i);
        if (stall_at >= 0) exp_lat += 3;
        model(n);
        check_eq({tag, "_in_ready"}, 64'(get_ready(n)), 64'd1);
        drive_s(n);
        set_in_valid(n, 1'b1);
        @(posedge clk); #1;
        set_in_valid(n, 1'b0);
        scramble_s(n);
        while (!get_valid(n) && cyc < 200) begin
            clk_en = !(stall_at >= 0 && cyc >= stall_at && cyc < stall_at + 3);
            @(posedge clk); #1;
            cyc++;
        end
        clk_en = 1'b1;
        check_eq({tag, "_latency"}, 64'(cyc), 64'(exp_lat));
        for (int e = 0; e < elems; e++)
            check_eq($sformatf("%s_z%0d", tag, e), 64'(get_z(n, e)), 64'(exp_z[e]));
        for (int h = 0; h < hold_cyc; h++) begin
            if (h == 1) begin
                scramble_s(n);
                set_in_valid(n, 1'b1);
            end else begin
                set_in_valid(n, 1'b0);
            end
            @(posedge clk); #1;
            check_eq($sformatf("%s_hold%0d_valid", tag, h), 64'(get_valid(n)), 64'd1);
            check_eq($sformatf("%s_hold%0d_ready", tag, h), 64'(get_ready(n)), 64'd0);
            for (int e = 0; e < elems; e++)
                check_eq($sformatf("%s_hold%0d_z%0d", tag, h, e), 64'(get_z(n, e)), 64'(exp_z[e]));
        end
        set_in_valid(n, 1'b0);
        set_out_ready(n, 1'b1);
        @(posedge clk); #1;
        set_out_ready(n, 1'b0);
        check_eq({tag, "_drop_valid"}, 64'(get_valid(n)), 64'd0);
        check_eq({tag, "_idle_ready"}, 64'(get_ready(n)), 64'd1);
        for (int e = 0; e < elems; e++)
            check_eq($sformatf("%s_keep_z%0d", tag, e), 64'(get_z(n, e)), 64'(exp_z[e]));
    endtask

    task automatic rand_matrix(input int n);
        bit big;
        big = ($urandom_range(0, 3) == 0);
        for (int e = 0; e < n*(n+1)/2; e++) begin
            if (big) s_in[e] = int'($urandom_range(0, (1 << 28) - 1)) - (1 << 27);
            else     s_in[e] = int'($urandom_range(0, (1 << 21) - 1)) - (1 << 20);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; clk_en = 1'b1;
        s2 = '0; s3 = '0;
        in_valid2 = 1'b0; out_ready2 = 1'b0;
        in_valid3 = 1'b0; out_ready3 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check_eq("rst_ready2", 64'(in_ready2), 64'd1);
        check_eq("rst_valid2", 64'(out_valid2), 64'd0);
        check_eq("rst_z2",     64'(z2 != '0), 64'd0);
        check_eq("rst_ready3", 64'(in_ready3), 64'd1);
        check_eq("rst_valid3", 64'(out_valid3), 64'd0);
        check_eq("rst_z3",     64'(z3 != '0), 64'd0);

        s_in[0] = 32'h0001_0000; s_in[1] = 32'h0000_8000; s_in[2] = 32'h0002_0000;
        run_case("basic", 2, -1, 0);
        s_in[1] = 32'hFFFF_8000;
        run_case("neg", 2, -1, 0);
        s_in[1] = 32'h0000_8000; s_in[2] = 32'h0100_0000;
        run_case("ovf", 2, -1, 0);

        s_in[0] = 32'h0001_0000; s_in[1] = 0; s_in[2] = 32'h0001_0000;
        s_in[3] = 0; s_in[4] = 0; s_in[5] = 32'h0001_0000;
        run_case("ident3", 3, -1, 0);

        s_in[0] = 32'h0001_0000; s_in[1] = 32'h0000_8000; s_in[2] = 32'h0002_0000;
        run_case("bp", 2, -1, 5);
        run_case("after_bp", 2, -1, 0);
        run_case("stall", 2, 1, 0);

        drive_s(2);
        set_in_valid(2, 1'b1);
        @(posedge clk); #1;
        set_in_valid(2, 1'b0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_eq("midrst_valid", 64'(out_valid2), 64'd0);
        check_eq("midrst_z",     64'(z2 != '0), 64'd0);
        check_eq("midrst_ready", 64'(in_ready2), 64'd1);

        for (int t = 0; t < 12; t++) begin
            rand_matrix(2);
            run_case($sformatf("rand2_%0d", t), 2, ($urandom_range(0, 3) == 0) ? 2 : -1, 0);
            rand_matrix(3);
            run_case($sformatf("rand3_%0d", t), 3, ($urandom_range(0, 3) == 0) ? 4 : -1, 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/inv_spd_from_chol_n.md
Name: inv_spd_from_chol_n

Overview:
- Computes the inverse of an N×N symmetric positive-definite matrix from its inverse Cholesky factor S = L^-1 (lower triangular), as Z = S^T·S.
- Generalises the fixed 2×2 inverse path to parametrised dimension, data width and fraction width.
- Adds a real in/out valid/ready handshake and a functional clk_en.
- Sits downstream of the inverse-Cholesky block; both S and Z use packed lower-triangle format.

Parameters:
- N, 2, matrix dimension; legal range 2..8.
- DW, 32, element width; signed two's complement fixed point.
- FRAC, 16, fractional bits per element (Q(DW-FRAC).FRAC).

Ports:
- clk  in  1  clock
- rst  in  1  reset
- clk_en  in  1  global advance enable; low freezes the block
- S  in  ELEMS*DW  packed inverse Cholesky factor, ELEMS = N*(N+1)/2
- in_valid  in  1  S valid
- in_ready  out  1  block can accept S
- Z  out  ELEMS*DW  packed lower triangle of the inverse
- out_valid  out  1  Z valid
- out_ready  out  1  consumer accepts Z — direction is in, see Behaviour

Behaviour:
- Interface: reset rst, synchronous, active-high; clock clk. out_ready is an input (consumer accepts Z).
- Packing: element (i,j), j<=i, 0-based, lives at index e = i*(i+1)/2 + j, bits [e*DW +: DW]. Applies to both S and Z.
- Math: for each i>=j, Z(i,j) = sum over k=i..N-1 of S(k,i)*S(k,j).
  - Products are full 2*DW signed.
  - Accumulator is 2*DW+3 bits signed.
  - Result = acc >>> FRAC (arithmetic shift, truncation toward -inf), narrowed to DW.
- Reset values: state=IDLE, in_ready=1, out_valid=0, Z=0, accumulator and counters=0. A reset mid-operation discards the in-flight matrix.
- Transfers: occur only on edges with clk_en=1. With clk_en=0, state, counters, accumulator, Z and the handshake outputs all hold.
- State IDLE:
  - in_ready=1.
  - On in_valid: capture S into an internal register, clear the accumulator, set i=j=0 and k=i, go to CALC.
- State CALC:
  - in_ready=0. One MAC term per enabled cycle: acc_next = acc + S(k,i)*S(k,j).
  - If k<N-1: k++.
  - If k==N-1: write the narrowed acc_next into Z(i,j), clear acc, then advance the element.
  - Element order is row-major: j++ while j<i; otherwise i++, j=0. On each new element, k restarts at the new i.
  - After the last element (N-1,N-1) is written, go to HOLD.
- State HOLD:
  - out_valid=1; Z stays stable; in_ready=0.
  - On out_ready: out_valid=0 and go to IDLE. A new matrix is accepted no earlier than the following cycle.
- Latency: T = sum over i=0..N-1 of (i+1)*(N-i) enabled cycles from the accepting edge to out_valid high. T=4 for N=2, 10 for N=3, 20 for N=4. Each cycle with clk_en=0 extends latency by one.
- Input handling:
  - in_valid while busy is ignored; no capture, no error.
  - Changes on S after acceptance have no effect.
- Z retains the last result after HOLD exits. Z is cleared only by rst.

Optional Feature:
- Macro INV_SPD_SATURATE_EN.
- Defined: if the shifted accumulator exceeds the signed DW range, the written element clamps to the signed max or min for DW bits (0x7FFFFFFF / 0x80000000 at DW=32).
- Undefined: the element is the low DW bits of the shifted accumulator (wrap).

Test Plan:
- Basic, N=2, DW=32, FRAC=16: S(0,0)=0x00010000, S(1,0)=0x00008000, S(1,1)=0x00020000 -> out_valid exactly 4 cycles after accept; Z(0,0)=0x00014000, Z(1,0)=0x00010000, Z(1,1)=0x00040000.
- Negative value: as above but S(1,0)=0xFFFF8000 -> Z(1,0)=0xFFFF0000, Z(0,0)=0x00014000, Z(1,1)=0x00040000.
- Overflow: S(1,1)=0x01000000 (256.0), other elements as in the basic test -> Z(1,1)=0x7FFFFFFF with INV_SPD_SATURATE_EN defined, 0x00000000 without it.
- N=3 identity: S diagonal = 0x00010000, off-diagonal = 0 -> Z = identity; out_valid exactly 10 cycles after accept.
- Backpressure and busy handling: hold out_ready=0 for 5 cycles -> Z stable, out_valid=1, in_ready=0, and an in_valid pulse is ignored. Then out_ready=1 -> out_valid drops; the next matrix is accepted in IDLE.
- Stall and reset: clk_en=0 for 3 cycles mid-CALC -> out_valid arrives at 7 cycles for N=2 with the same Z. In a separate run, rst asserted mid-CALC -> out_valid=0, Z=0, in_ready=1 the next cycle.
